// File: rtl/io_port_responder.sv
// Strobed 8-bit IO bus responder: GPIO output latches, synchronised GPIO inputs, TX/RX byte FIFOs.
// Optional IO_RESP_IRQ_EN adds an IRQ_MASK register at port 0x14 and a registered irq output.
module io_port_responder #(
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_GPO    = 2,
  parameter int NUM_GPI    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           IO_port_ID,
  input  logic [7:0]           IO_write_data,
  input  logic                 IO_write_strobe,
  input  logic                 IO_read_strobe,
  output logic [7:0]           IO_read_data,
  output logic [8*NUM_GPO-1:0] gpo,
  input  logic [8*NUM_GPI-1:0] gpi,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [7:0] PORT_STATUS   = 8'h10;
  localparam logic [7:0] PORT_TX_DATA  = 8'h11;
  localparam logic [7:0] PORT_RX_DATA  = 8'h12;
  localparam logic [7:0] PORT_RX_COUNT = 8'h13;
  localparam logic [7:0] PORT_IRQ_MASK = 8'h14;

  logic [8*NUM_GPO-1:0] gpo_q;
  logic [8*NUM_GPI-1:0] gpi_meta;
  logic [8*NUM_GPI-1:0] gpi_sync;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr;
  logic [AW-1:0] tx_rd_ptr;
  logic [CW-1:0] tx_count;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr;
  logic [AW-1:0] rx_rd_ptr;
  logic [CW-1:0] rx_count;

  logic tx_overflow;
  logic rx_underflow;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push_req, tx_push, tx_pop, tx_overflow_evt;
  logic rx_pop_req, rx_push, rx_pop, rx_underflow_evt;
  logic wr_status;
  logic [7:0] status;

  assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_count == '0);

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rd_ptr];
  assign rx_ready = !rx_full;
  assign gpo      = gpo_q;

  assign wr_status   = IO_write_strobe && (IO_port_ID == PORT_STATUS);
  assign tx_push_req = IO_write_strobe && (IO_port_ID == PORT_TX_DATA);
  assign rx_pop_req  = IO_read_strobe && (IO_port_ID == PORT_RX_DATA);

  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign tx_pop          = tx_valid && tx_ready;
  assign tx_push         = tx_push_req && (!tx_full || tx_pop);
  assign tx_overflow_evt = tx_push_req && tx_full && !tx_pop;

  assign rx_push          = rx_valid && rx_ready;
  assign rx_pop           = rx_pop_req && !rx_empty;
  assign rx_underflow_evt = rx_pop_req && rx_empty;

  assign status = {2'b00, rx_underflow, tx_overflow, rx_full, rx_empty, tx_empty, tx_full};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpo_q <= '0;
    end else if (IO_write_strobe) begin
      for (int i = 0; i < NUM_GPO; i++) begin
        if (IO_port_ID == 8'(i)) gpo_q[8*i +: 8] <= IO_write_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpi_meta <= '0;
      gpi_sync <= '0;
    end else begin
      gpi_meta <= gpi;
      gpi_sync <= gpi_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= IO_write_data;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);
    end
  end

  // New events take priority over a W1C write landing in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (tx_overflow_evt)                     tx_overflow <= 1'b1;
      else if (wr_status && IO_write_data[4])  tx_overflow <= 1'b0;
      if (rx_underflow_evt)                    rx_underflow <= 1'b1;
      else if (wr_status && IO_write_data[5])  rx_underflow <= 1'b0;
    end
  end

`ifdef IO_RESP_IRQ_EN
  logic [2:0] irq_mask;
  logic [2:0] irq_cond;
  logic       irq_q;

  assign irq_cond = {tx_overflow | rx_underflow, tx_empty, !rx_empty};
  assign irq      = irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (IO_write_strobe && (IO_port_ID == PORT_IRQ_MASK)) irq_mask <= IO_write_data[2:0];
      irq_q <= |(irq_mask & irq_cond);
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    IO_read_data = 8'h00;
    for (int i = 0; i < NUM_GPO; i++) begin
      if (IO_port_ID == 8'(i)) IO_read_data = gpo_q[8*i +: 8];
    end
    for (int i = 0; i < NUM_GPI; i++) begin
      if (IO_port_ID == 8'(4 + i)) IO_read_data = gpi_sync[8*i +: 8];
    end
    case (IO_port_ID)
      PORT_STATUS:   IO_read_data = status;
      PORT_RX_DATA:  IO_read_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
      PORT_RX_COUNT: IO_read_data = 8'(rx_count);
`ifdef IO_RESP_IRQ_EN
      PORT_IRQ_MASK: IO_read_data = {5'b00000, irq_mask};
`endif
      default: ;
    endcase
  end

endmodule
